// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants for the F1->F2 elastic queue.
package fetch_pkg;

   typedef struct packed {
      logic pred_taken;
      logic misalign;
   } fetch_side_t;

   localparam int unsigned PC_RESET = 0;

   // Elastic queue depth must be a power of two in 2..8 so the pointers wrap for free.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && (depth <= 8) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Pointer, occupancy and flushed-bubble control for the F1->F2 queue; arbitrates hold > flush > push/pop.
module fifo_ptr_ctl
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1),
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             hold,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic             push,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [CNT_W-1:0] count,
   output logic             out_flushed
);

   logic pop;

   always_comb begin
      in_ready  = (count != CNT_W'(DEPTH)) && !hold;
      out_valid = (count != '0);
      push      = in_valid && in_ready && !flush;
      pop       = out_valid && out_ready && !hold && !flush;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         out_flushed <= 1'b0;
      end else if (!hold) begin
         if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            out_flushed <= 1'b1;
         end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) out_flushed <= 1'b0;
         end
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (!nrst) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/f1_f2_skidq.sv
// F1->F2 fetch elastic queue: DEPTH-entry circular buffer with valid/ready on both sides and flushed-bubble flag.
module f1_f2_skidq
   import fetch_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter int SIDE_W = 2,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              hold,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [SIDE_W-1:0] in_side,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [SIDE_W-1:0] out_side,
   output logic              out_is_inst,
   output logic              out_flushed,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = PC_W + SIDE_W;

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("f1_f2_skidq: DEPTH must be a power of two in 2..8");
   end
   if (SIDE_W < 1) begin : g_bad_side
      $error("f1_f2_skidq: SIDE_W must be at least 1");
   end

   logic [ENT_W-1:0] mem [DEPTH];
   logic [ENT_W-1:0] head_ent;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             push;

   fifo_ptr_ctl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .PTR_W (PTR_W)
   ) u_ptr_ctl (
      .clk         (clk),
      .nrst        (nrst),
      .hold        (hold),
      .flush       (flush),
      .in_valid    (in_valid),
      .out_ready   (out_ready),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .push        (push),
      .head        (head),
      .tail        (tail),
      .count       (count),
      .out_flushed (out_flushed)
   );

   // Storage carries no reset; empty-queue outputs are masked by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= {in_pc, in_side};
   end

   always_comb begin
      head_ent    = mem[head];
      out_pc      = out_valid ? head_ent[ENT_W-1 -: PC_W] : PC_W'(PC_RESET);
      out_side    = out_valid ? head_ent[SIDE_W-1:0] : '0;
      out_is_inst = out_valid;
   end

endmodule
